// File: rtl/fetch_npc_gen_pkg.sv
// Shared constants and types for the next-PC generator slice.
// Holds address width, fetch-group alignment and FSM state encodings.
package fetch_npc_gen_pkg;

   localparam int NPC_ADDR_LEN = 32;
   localparam int ADDR_LEN     = NPC_ADDR_LEN;
   localparam int FETCH_ALIGN  = 3;

   typedef enum logic [1:0] {
      NPC_BUBBLE = 2'd0,
      NPC_RUN    = 2'd1,
      NPC_STALL  = 2'd2
   } npc_state_e;

endpackage

// File: rtl/fetch_npc_gen_if.sv
// Fetch-group handshake from the next-PC generator to decode.
// master: drives out_valid/out_pc/out_inv2/out_pred_*; slave: drives out_ready.
interface fetch_npc_gen_if #(
   parameter int AW = 32
);
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_pc;
   logic          out_inv2;
   logic          out_pred_taken;
   logic [AW-1:0] out_pred_tgt;

   modport master (
      output out_valid, out_pc, out_inv2,
      output out_pred_taken, out_pred_tgt,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_pc, out_inv2,
      input  out_pred_taken, out_pred_tgt,
      output out_ready
   );
endinterface

// File: rtl/fetch_skid2.sv
// Two-entry FIFO skid buffer with flush; head entry drives dout_o.
// Ports: push_i/din_i in, ready_i/valid_o/dout_o out, space_o = can push now.
module fetch_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] dout_o,
   output logic         space_o
);
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop;

   assign valid_o = (cnt_q != 2'd0);
   assign pop     = valid_o & ready_i;
   // A pop from a full buffer frees a slot in the same cycle.
   assign space_o = (cnt_q != 2'd2) | pop;
   assign dout_o  = e0_q;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = 2'd0;
      end else begin
         unique case ({push_i, pop})
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  e0_d = e1_q;
                  e1_d = din_i;
               end else begin
                  e0_d = din_i;
               end
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = din_i;
               else               e1_d = din_i;
               cnt_d = cnt_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/fetch_npc_gen.sv
// Next-PC generator: picks redirect/predicted/sequential/hold PC and issues
// 2-wide fetch groups via out_if; btb_* is the same-cycle BTB lookup.
// Optional NPC_PHT_GATE_EN: a BTB hit is taken only when pht_taken is set.
module fetch_npc_gen
   import fetch_npc_gen_pkg::*;
#(
   parameter int                  ADDR_LEN   = NPC_ADDR_LEN,
   parameter logic [ADDR_LEN-1:0] RESET_PC   = '0,
   parameter int                  BUBBLE_CYC = 1
) (
   input  logic                clk,
   input  logic                reset,
   output logic [ADDR_LEN-1:0] btb_pc,
   output logic                btb_invalid2,
   input  logic                btb_hit,
   input  logic [ADDR_LEN-1:0] btb_jmpaddr,
   input  logic                pht_taken,
   input  logic                redirect,
   input  logic [ADDR_LEN-1:0] redirect_pc,
   fetch_npc_gen_if.master     out_if
);
   localparam int         W       = 2 * ADDR_LEN + 2;
   localparam int         HI      = ADDR_LEN - FETCH_ALIGN;
   localparam logic [1:0] BCNT    = 2'(BUBBLE_CYC);
   localparam npc_state_e ST_INIT =
      (BUBBLE_CYC == 0) ? NPC_RUN : NPC_BUBBLE;

   npc_state_e          state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [ADDR_LEN-1:0] pc_q, pc_d;
   logic [ADDR_LEN-1:0] seq_pc, tgt;
   logic                taken, push, space;
   logic [W-1:0]        dout;

   assign btb_pc       = pc_q;
   assign btb_invalid2 = pc_q[2];
   assign seq_pc = {pc_q[ADDR_LEN-1:FETCH_ALIGN] + HI'(1),
                    {FETCH_ALIGN{1'b0}}};

`ifdef NPC_PHT_GATE_EN
   assign taken = btb_hit & pht_taken;
`else
   logic unused_pht;
   assign unused_pht = pht_taken;
   assign taken      = btb_hit;
`endif

   assign tgt = taken ? btb_jmpaddr : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= BCNT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      if (redirect) begin
         state_d = ST_INIT;
         cnt_d   = BCNT;
         pc_d    = redirect_pc;
      end else begin
         unique case (state_q)
            NPC_BUBBLE: begin
               cnt_d = cnt_q - 2'd1;
               if (cnt_q <= 2'd1) state_d = NPC_RUN;
            end
            NPC_RUN: begin
               if (space) pc_d = taken ? btb_jmpaddr : seq_pc;
               else       state_d = NPC_STALL;
            end
            NPC_STALL: begin
               if (space) state_d = NPC_RUN;
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_comb begin
      push = !redirect && (state_q == NPC_RUN) && space;
   end

   fetch_skid2 #(.W(W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect),
      .push_i  (push),
      .din_i   ({pc_q, pc_q[2], taken, tgt}),
      .ready_i (out_if.out_ready),
      .valid_o (out_if.out_valid),
      .dout_o  (dout),
      .space_o (space)
   );

   assign {out_if.out_pc, out_if.out_inv2,
           out_if.out_pred_taken, out_if.out_pred_tgt} = dout;
endmodule

// File: tb/tb_fetch_npc_gen.sv
// Scoreboard bench for fetch_npc_gen with a behavioural BTB.
// Expected group streams are queued on each redirect/reset and popped per handshake.
module tb_fetch_npc_gen;
   import fetch_npc_gen_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] btb_pc;
   logic        btb_invalid2;
   logic        btb_hit;
   logic [31:0] btb_jmpaddr;
   logic        pht_taken;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        hit_en;
   logic [31:0] hit_pc, hit_tgt;

   typedef struct {
      logic [31:0] pc;
      logic        inv2;
      logic        tk;
      logic [31:0] tgt;
   } grp_t;

   grp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   hs = 0;

   always #5 clk = ~clk;

   assign btb_hit     = hit_en && (btb_pc == hit_pc);
   assign btb_jmpaddr = hit_tgt;

   fetch_npc_gen_if #(.AW(32)) oif ();

   fetch_npc_gen #(
      .ADDR_LEN   (32),
      .RESET_PC   (32'h100),
      .BUBBLE_CYC (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btb_pc       (btb_pc),
      .btb_invalid2 (btb_invalid2),
      .btb_hit      (btb_hit),
      .btb_jmpaddr  (btb_jmpaddr),
      .pht_taken    (pht_taken),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .out_if       (oif)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic mdl_taken(input logic [31:0] p);
`ifdef NPC_PHT_GATE_EN
      return hit_en && (p == hit_pc) && pht_taken;
`else
      return hit_en && (p == hit_pc);
`endif
   endfunction

   task automatic load(input logic [31:0] start);
      logic [31:0] p;
      grp_t        g;
      sb.delete();
      p = start;
      repeat (64) begin
         g.pc   = p;
         g.inv2 = p[2];
         g.tk   = mdl_taken(p);
         g.tgt  = g.tk ? hit_tgt : 32'h0;
         sb.push_back(g);
         p = g.tk ? hit_tgt : {p[31:3] + 29'd1, 3'b000};
      end
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic tick();
      grp_t g;
      #1;
      if (oif.out_valid && oif.out_ready) begin
         hs++;
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            g = sb.pop_front();
            chk("grp_pc", oif.out_pc, g.pc);
            chk("grp_inv2", 32'(oif.out_inv2), 32'(g.inv2));
            chk("grp_taken", 32'(oif.out_pred_taken), 32'(g.tk));
            chk("grp_tgt", oif.out_pred_tgt, g.tgt);
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic rdy);
      repeat (n) begin
         oif.out_ready = rdy;
         tick();
      end
   endtask

   task automatic redir(input logic [31:0] p, input logic rdy);
      redirect      = 1'b1;
      redirect_pc   = p;
      oif.out_ready = rdy;
      tick();
      redirect = 1'b0;
      load(p);
      chk("flush_valid", 32'(oif.out_valid), 32'd0);
      chk("redir_pc", btb_pc, p);
   endtask

   initial begin
      int h0;
      reset         = 1'b1;
      redirect      = 1'b0;
      redirect_pc   = '0;
      pht_taken     = 1'b0;
      hit_en        = 1'b0;
      hit_pc        = '0;
      hit_tgt       = '0;
      oif.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(oif.out_valid), 32'd0);
      chk("rst_out_pc", oif.out_pc, 32'h0);
      chk("rst_tgt", oif.out_pred_tgt, 32'h0);
      chk("rst_btb_pc", btb_pc, 32'h100);

      // Reset release: one bubble cycle, then 0x100, 0x108, 0x110...
      reset         = 1'b0;
      oif.out_ready = 1'b1;
      load(32'h100);
      tick();
      chk("bubble_valid", 32'(oif.out_valid), 32'd0);
      tick();
      chk("first_valid", 32'(oif.out_valid), 32'd1);
      chk("first_pc", oif.out_pc, 32'h100);
      h0 = hs;
      run(6, 1'b1);
      chk("seq_progress", 32'(hs - h0), 32'd6);

      // Redirect to an odd-slot address.
      redir(32'h204, 1'b1);
      tick();
      chk("redir_bubble", 32'(oif.out_valid), 32'd0);
      tick();
      chk("redir_valid", 32'(oif.out_valid), 32'd1);
      chk("redir_out_pc", oif.out_pc, 32'h204);
      chk("redir_inv2", 32'(oif.out_inv2), 32'd1);
      run(4, 1'b1);

      // BTB hit at 0x110 -> 0x40.
      hit_en  = 1'b1;
      hit_pc  = 32'h110;
      hit_tgt = 32'h40;
      pht_taken = 1'b1;
      redir(32'h100, 1'b1);
      h0 = hs;
      run(10, 1'b1);
      chk("hit_progress", 32'(hs - h0), 32'd8);

      // Decode stalls: two groups buffered, pc held.
      hit_en = 1'b0;
      redir(32'h100, 1'b0);
      run(5, 1'b0);
      chk("stall_btb_pc", btb_pc, 32'h110);
      chk("stall_valid", 32'(oif.out_valid), 32'd1);
      chk("stall_head", oif.out_pc, 32'h100);
      h0 = hs;
      run(8, 1'b1);
      chk("drain_progress", 32'(hs >= h0 + 6), 32'd1);

      // Redirect coincides with full-buffer pop and a BTB hit.
      hit_en  = 1'b1;
      hit_pc  = 32'h110;
      hit_tgt = 32'h40;
      redir(32'h100, 1'b0);
      run(5, 1'b0);
      chk("full_btb_pc", btb_pc, 32'h110);
      redir(32'h300, 1'b1);
      h0 = hs;
      run(6, 1'b1);
      chk("flush_progress", 32'(hs >= h0 + 3), 32'd1);

      // Address wrap, no hit.
      hit_en = 1'b0;
      redir(32'hFFFF_FFF8, 1'b1);
      run(6, 1'b1);

      // Hit at the wrap point with a not-taken direction.
      hit_en    = 1'b1;
      hit_pc    = 32'hFFFF_FFF8;
      hit_tgt   = 32'h500;
      pht_taken = 1'b0;
      redir(32'hFFFF_FFF8, 1'b1);
      run(6, 1'b1);

      // Random decode backpressure over a taken loop.
      hit_pc    = 32'h118;
      hit_tgt   = 32'h104;
      pht_taken = 1'b1;
      redir(32'h100, 1'b1);
      h0 = hs;
      repeat (40) begin
         oif.out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      run(4, 1'b1);
      chk("rand_progress", 32'(hs >= h0 + 8), 32'd1);

      // Reset mid-operation with data buffered.
      run(3, 1'b0);
      reset = 1'b1;
      tick();
      chk("mrst_valid", 32'(oif.out_valid), 32'd0);
      chk("mrst_out_pc", oif.out_pc, 32'h0);
      chk("mrst_taken", 32'(oif.out_pred_taken), 32'd0);
      chk("mrst_btb_pc", btb_pc, 32'h100);
      hit_en = 1'b0;
      reset  = 1'b0;
      load(32'h100);
      oif.out_ready = 1'b1;
      tick();
      chk("mrst_bubble", 32'(oif.out_valid), 32'd0);
      h0 = hs;
      run(6, 1'b1);
      chk("mrst_progress", 32'(hs - h0), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_npc_gen.md
Name: fetch_npc_gen

Overview:
- Next-PC generator and fetch-group issuer.
- Sits directly upstream of the BTB: drives the BTB `pc`/`invalid2` lookup inputs and consumes its `hit`/`jmpaddr` in the same cycle.
- Selects the next fetch address from four sources: redirect, prediction, sequential, hold.
- Delivers 2-wide fetch groups to decode through a valid/ready handshake with a 2-entry skid buffer.

Parameters:
- ADDR_LEN, 32, address width (matches `ADDR_LEN`).
- RESET_PC, 32'h0, first fetch address after reset.
- BUBBLE_CYC, 1, fetch-invalid cycles after a redirect (0..3).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- btb_pc  out  ADDR_LEN  current PC presented to BTB lookup.
- btb_invalid2  out  1  slot-2 invalid for lookup; equals `btb_pc[2]`.
- btb_hit  in  1  BTB hit for the current group (combinational, same cycle).
- btb_jmpaddr  in  ADDR_LEN  predicted target.
- pht_taken  in  1  direction prediction (used only with the optional feature).
- redirect  in  1  mispredict/exception redirect from the branch unit.
- redirect_pc  in  ADDR_LEN  redirect target.
- out_valid  out  1  fetch group valid to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  ADDR_LEN  group PC.
- out_inv2  out  1  slot 2 of the group is invalid.
- out_pred_taken  out  1  group was predicted taken.
- out_pred_tgt  out  ADDR_LEN  predicted target (0 when not taken).

Behaviour:
- Reset:
  - pc <= RESET_PC, state <= BUBBLE, bubble counter <= BUBBLE_CYC.
  - Skid buffer emptied; out_valid = 0; out_pc, out_pred_tgt = 0; out_inv2, out_pred_taken = 0.
  - Reset asserted mid-operation discards everything with the same result.
- Group formation:
  - Group = {pc, pc+4} on an 8-byte boundary.
  - inv2 = pc[2].
  - Sequential next = {pc[ADDR_LEN-1:3] + 1, 3'b000}; wrap-around modulo 2^ADDR_LEN.
- Taken decision:
  - taken = btb_hit (without the optional feature).
  - Predicted next = btb_jmpaddr.
- States:
  - BUBBLE: no group is issued.
    - Counter decrements each cycle; at 0 → RUN.
    - With BUBBLE_CYC = 0, BUBBLE is skipped entirely (redirect and reset go straight to RUN).
  - RUN: if skid buffer has space, push group {pc, inv2, taken, tgt}, then pc <= taken ? btb_jmpaddr : seq.
    - Skid buffer full → state STALL, pc held.
  - STALL: pc held; → RUN when the skid buffer has a free entry.
    - BTB lookup repeats with the same pc, so the result must be identical.
- Redirect:
  - Highest priority in every state.
  - pc <= redirect_pc; skid buffer flushed (out_valid = 0 next cycle).
  - state <= BUBBLE with counter = BUBBLE_CYC.
  - The same-cycle push is suppressed.
  - A redirect arriving during BUBBLE restarts the counter.
- Skid buffer:
  - 2 entries, FIFO order.
  - out_* driven from the head entry.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop when full is allowed: the pop frees the entry in the same cycle.
  - out_valid = !empty.
- Latency: pc to out_valid is 1 cycle when the buffer is empty. No combinational path from out_ready to btb_pc.
- Predicted-target field: out_pred_tgt = btb_jmpaddr when taken, else 0.

Optional Feature:
- Macro: NPC_PHT_GATE_EN.
- Defined: taken = btb_hit & pht_taken. A BTB hit with a not-taken direction follows the sequential path.
- Undefined: pht_taken is ignored and taken = btb_hit.

Decomposition:
- Shared constants header (`constants.vh`) holds:
  - ADDR_LEN.
  - Fetch-group alignment constant: FETCH_ALIGN = 3.
  - State encodings: NPC_BUBBLE = 2'd0, NPC_RUN = 2'd1, NPC_STALL = 2'd2.
- One sub-module: fetch_skid2 (2-entry valid/ready FIFO with flush), parameterised on payload width.

Test Plan:
- Reset, RESET_PC = 0x100, out_ready = 1, no hits:
  - Bubble for 1 cycle.
  - Then out_pc = 0x100, 0x108, 0x110 on consecutive cycles, all with out_inv2 = 0.
- Redirect to 0x204:
  - After the bubble, out_pc = 0x204 with out_inv2 = 1.
  - Next out_pc = 0x208.
- btb_hit = 1, jmpaddr = 0x40 at pc 0x110:
  - Group shows out_pred_taken = 1, out_pred_tgt = 0x40.
  - Next out_pc = 0x40.
- out_ready = 0 for 5 cycles from pc 0x100:
  - Exactly 2 groups buffered (0x100, 0x108); pc holds at 0x110.
  - On ready, groups drain in order with no duplication or loss.
- Redirect in the same cycle as a full-buffer pop and a BTB hit:
  - Buffer flushed; the predicted target is discarded.
  - Next issued pc = redirect_pc.
- Wrap: pc = 0xFFFF_FFF8, no hit → next out_pc = 0x0.
  - With NPC_PHT_GATE_EN: btb_hit = 1, pht_taken = 0 → sequential path, out_pred_taken = 0.
